// File: rtl/aibio_rxdll_pkg.sv
// Shared types and constants for the RX DLL lock monitor.
package aibio_rxdll_pkg;

    // Per-channel lock FSM states
    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        ACQUIRE  = 2'd2,
        LOCKED   = 2'd3
    } lock_state_t;

    // Default parameter values
    localparam int unsigned DEF_NCH   = 4;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_HYS_W = 4;

    // Largest value of a w-bit unsigned field; used as saturation limits
    function automatic int unsigned sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam int unsigned DEF_NET_SAT = (32'd1 << DEF_CNT_W) - 32'd1;
    localparam int unsigned DEF_HYS_SAT = (32'd1 << DEF_HYS_W) - 32'd1;

endpackage

// File: rtl/aibio_rxdll_lock_ch.sv
// One monitored DLL channel: up/dn synchronisers, windowed net accumulator,
// lock/unlock hysteresis FSM and sticky loss-of-lock flag.
module aibio_rxdll_lock_ch
    import aibio_rxdll_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned HYS_W = DEF_HYS_W
) (
    input  logic             i_clkin,
    input  logic             i_resetb,
    input  logic             i_ch_en,
    input  logic             i_up,
    input  logic             i_dn,
    input  logic             i_win_end,
    input  logic [CNT_W-1:0] i_lockthresh,
    input  logic [HYS_W-1:0] i_lock_cnt,
    input  logic [HYS_W-1:0] i_unlock_cnt,
    input  logic             i_lol_clr,
    output logic             o_dll_lock,
    output logic             o_lol
);

    localparam int unsigned             NET_W   = CNT_W + 1;
    localparam logic signed [NET_W-1:0] NET_MAX = NET_W'(sat_max(CNT_W));
    localparam logic signed [NET_W-1:0] NET_MIN = -NET_MAX;
    localparam logic signed [NET_W-1:0] NET_ONE = NET_W'(1);
    localparam logic        [HYS_W-1:0] HYS_MAX = HYS_W'(sat_max(HYS_W));
    localparam logic        [HYS_W-1:0] HYS_ONE = HYS_W'(1);

    logic [1:0]              up_sync;
    logic [1:0]              dn_sync;
    logic                    up_s;
    logic                    dn_s;
    logic signed [NET_W-1:0] net_q;
    logic signed [NET_W-1:0] net_sum;
    logic        [NET_W-1:0] net_abs;
    logic                    good_win;
    lock_state_t             state_q;
    lock_state_t             state_d;
    logic        [HYS_W-1:0] hys_q;
    logic        [HYS_W-1:0] hys_d;
    logic        [HYS_W-1:0] hys_inc;
    logic        [HYS_W-1:0] lock_need;
    logic        [HYS_W-1:0] unlock_need;
    logic                    lol_set;

    assign up_s        = up_sync[1];
    assign dn_s        = dn_sync[1];
    assign lock_need   = (i_lock_cnt   == '0) ? HYS_ONE : i_lock_cnt;
    assign unlock_need = (i_unlock_cnt == '0) ? HYS_ONE : i_unlock_cnt;
    assign hys_inc     = (hys_q == HYS_MAX) ? hys_q : hys_q + HYS_ONE;
    assign o_dll_lock  = (state_q == LOCKED);

    // Two-flop synchronisers for the asynchronous phase-detector outputs
    always_ff @(posedge i_clkin) begin
        if (!i_resetb) begin
            up_sync <= '0;
            dn_sync <= '0;
        end else begin
            up_sync <= {up_sync[0], i_up};
            dn_sync <= {dn_sync[0], i_dn};
        end
    end

    // Saturating net step including this cycle's sample, and its magnitude
    always_comb begin
        net_sum = net_q;
        if (up_s && !dn_s && (net_q != NET_MAX)) begin
            net_sum = net_q + NET_ONE;
        end else if (dn_s && !up_s && (net_q != NET_MIN)) begin
            net_sum = net_q - NET_ONE;
        end
        net_abs  = net_sum[NET_W-1] ? $unsigned(-net_sum) : $unsigned(net_sum);
        good_win = (net_abs <= {1'b0, i_lockthresh});
    end

    // Net accumulator: restarts from zero after every window end
    always_ff @(posedge i_clkin) begin
        if (!i_resetb || (state_q == DISABLED) || i_win_end) begin
            net_q <= '0;
        end else begin
            net_q <= net_sum;
        end
    end

    // State and hysteresis counter registers
    always_ff @(posedge i_clkin) begin
        if (!i_resetb) begin
            state_q <= DISABLED;
            hys_q   <= '0;
        end else begin
            state_q <= state_d;
            hys_q   <= hys_d;
        end
    end

    // Next-state logic; one hysteresis counter serves as the good-window
    // count in ACQUIRE and the bad-window count in LOCKED, since every
    // transition between those states clears it
    always_comb begin
        state_d = state_q;
        hys_d   = hys_q;
        lol_set = 1'b0;
        if (!i_ch_en) begin
            state_d = DISABLED;
            hys_d   = '0;
        end else begin
            case (state_q)
                DISABLED: begin
                    state_d = ARMED;
                    hys_d   = '0;
                end
                ARMED: begin
                    if (i_win_end) begin
                        state_d = ACQUIRE;
                        hys_d   = '0;
                    end
                end
                ACQUIRE: begin
                    if (i_win_end) begin
                        if (!good_win) begin
                            hys_d = '0;
                        end else if (hys_inc >= lock_need) begin
                            state_d = LOCKED;
                            hys_d   = '0;
                        end else begin
                            hys_d = hys_inc;
                        end
                    end
                end
                LOCKED: begin
                    if (i_win_end) begin
                        if (good_win) begin
                            hys_d = '0;
                        end else if (hys_inc >= unlock_need) begin
                            state_d = ACQUIRE;
                            hys_d   = '0;
                            lol_set = 1'b1;
                        end else begin
                            hys_d = hys_inc;
                        end
                    end
                end
                default: begin
                    state_d = DISABLED;
                    hys_d   = '0;
                end
            endcase
        end
    end

    // Sticky loss-of-lock; a new set wins over a simultaneous clear
    always_ff @(posedge i_clkin) begin
        if (!i_resetb) begin
            o_lol <= 1'b0;
        end else if (lol_set) begin
            o_lol <= 1'b1;
        end else if (i_lol_clr) begin
            o_lol <= 1'b0;
        end
    end

endmodule

// File: rtl/aibio_rxdll_lock_monitor.sv
// Multi-channel RX DLL lock monitor: shared window counter, per-channel
// lock detectors, all-lock reduction and PI code update handshake.
module aibio_rxdll_lock_monitor
    import aibio_rxdll_pkg::*;
#(
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned HYS_W = DEF_HYS_W
) (
    input  logic             i_clkin,
    input  logic             i_resetb,
    input  logic [NCH-1:0]   i_ch_en,
    input  logic [NCH-1:0]   i_up,
    input  logic [NCH-1:0]   i_dn,
    input  logic [CNT_W-1:0] i_win_len,
    input  logic [CNT_W-1:0] i_lockthresh,
    input  logic [HYS_W-1:0] i_lock_cnt,
    input  logic [HYS_W-1:0] i_unlock_cnt,
    input  logic             i_lol_clr,
    input  logic             i_upd_req,
    output logic [NCH-1:0]   o_dll_lock,
    output logic             o_all_lock,
    output logic [NCH-1:0]   o_lol,
    output logic             o_picode_update,
    output logic             o_upd_ack
);

    logic [CNT_W-1:0] win_cnt_q;
    logic             any_en;
    logic             win_end;
    logic             upd_q;

    assign any_en  = |i_ch_en;
    assign win_end = any_en && (win_cnt_q == i_win_len);

    // Shared window counter, free-running while any channel is enabled
    always_ff @(posedge i_clkin) begin
        if (!i_resetb || !any_en || win_end) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_q + CNT_W'(1);
        end
    end

    for (genvar ch = 0; ch < int'(NCH); ch++) begin : g_ch
        aibio_rxdll_lock_ch #(
            .CNT_W (CNT_W),
            .HYS_W (HYS_W)
        ) u_ch (
            .i_clkin      (i_clkin),
            .i_resetb     (i_resetb),
            .i_ch_en      (i_ch_en[ch]),
            .i_up         (i_up[ch]),
            .i_dn         (i_dn[ch]),
            .i_win_end    (win_end),
            .i_lockthresh (i_lockthresh),
            .i_lock_cnt   (i_lock_cnt),
            .i_unlock_cnt (i_unlock_cnt),
            .i_lol_clr    (i_lol_clr),
            .o_dll_lock   (o_dll_lock[ch]),
            .o_lol        (o_lol[ch])
        );
    end

    assign o_all_lock = any_en && (&(o_dll_lock | ~i_ch_en));

    // Update pulse: only while all enabled channels are locked, never twice in a row
    always_ff @(posedge i_clkin) begin
        if (!i_resetb) begin
            upd_q <= 1'b0;
        end else begin
            upd_q <= i_upd_req && o_all_lock && !upd_q;
        end
    end

    assign o_picode_update = upd_q;
    assign o_upd_ack       = upd_q;

endmodule
